l2_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single L2/memory request port between three requesters: 0 = I-cache refill, 1 = D-cache refill, 2 = D-cache writeback.
- Drives the select of the 3:1 address/data mux in front of the L2 port. The select encoding matches that mux: 00/01/10 pick a requester; 11 yields zero, which is the idle value.
- Holds a grant for the whole memory transaction, pulses completion back to the winner, and flags memory timeouts.

---
 rtl/l2_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin owner of the single L2 request port.
// Requesters: 0 I-refill, 1 D-refill, 2 D-writeback.
//
// Ports:
//   clk, rst     clock; synchronous active-low reset
//   req[2:0]     request levels, held until the matching done bit
//   mem_ack      one-cycle completion pulse from L2
//   gnt[2:0]     one-hot grant, held for the whole transaction
//   sel[1:0]     address/data mux select, 2'b11 = idle (mux yields zero)
//   mem_req      request to L2, high while a grant is held
//   done[2:0]    one-cycle completion pulse to the winner
//   busy         high while a transaction is open or being released
//   timeout_err  flags a release forced by the watchdog (with done)
module l2_port_arbiter #(
  parameter int NREQ           = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            mem_ack,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            mem_req,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_nx;

  logic [1:0]       ptr, ptr_nx;
  logic [1:0]       win, win_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [2:0] gnt_nx;
  logic [1:0] sel_nx;
  logic       mem_req_nx;
  logic [2:0] done_nx;
  logic       busy_nx;
  logic       tmo_nx;

  // modulo-3 increment of a requester index
  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] k);
    logic [2:0] r;
    r = 3'b000;
    case (k)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  // Search order ptr, ptr+1, ptr+2; first live request wins.
  logic [1:0] c0, c1, c2;
  logic       hit0, hit1;
  logic [1:0] pick;

  always_comb begin
    c0   = ptr;
    c1   = inc3(ptr);
    c2   = inc3(c1);
    hit0 = |(req & onehot(c0));
    hit1 = |(req & onehot(c1));
    pick = c2;
    priority case (1'b1)
      hit0:    pick = c0;
      hit1:    pick = c1;
      default: pick = c2;
    endcase
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    win_nx     = win;
    cnt_nx     = cnt;
    gnt_nx     = 3'b000;
    sel_nx     = 2'b11;
    mem_req_nx = 1'b0;
    done_nx    = 3'b000;
    busy_nx    = 1'b0;
    tmo_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx   = BUSY;
          win_nx     = pick;
          ptr_nx     = inc3(pick);
          cnt_nx     = '0;
          gnt_nx     = onehot(pick);
          sel_nx     = pick;
          mem_req_nx = 1'b1;
          busy_nx    = 1'b1;
        end
      end
      BUSY: begin
        cnt_nx  = cnt + 1'b1;
        busy_nx = 1'b1;
        if (mem_ack) begin
          state_nx = RELEASE;
          done_nx  = onehot(win);
        end else if (TMO_EN && cnt == TMO_LAST) begin
          state_nx = RELEASE;
          done_nx  = onehot(win);
          tmo_nx   = 1'b1;
        end else begin
          gnt_nx     = onehot(win);
          sel_nx     = win;
          mem_req_nx = 1'b1;
        end
      end
      RELEASE: begin
        // req is ignored here so the winner can drop it
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      win         <= 2'd0;
      cnt         <= '0;
      gnt         <= 3'b000;
      sel         <= 2'b11;
      mem_req     <= 1'b0;
      done        <= 3'b000;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      win         <= win_nx;
      cnt         <= cnt_nx;
      gnt         <= gnt_nx;
      sel         <= sel_nx;
      mem_req     <= mem_req_nx;
      done        <= done_nx;
      busy        <= busy_nx;
      timeout_err <= tmo_nx;
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed scoreboard bench for l2_port_arbiter.
// Grant and done events are queued by stimulus, popped by a monitor.
module tb_l2_port_arbiter;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic       mem_ack = 1'b0;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       mem_req;
  logic [2:0] done;
  logic       busy;
  logic       timeout_err;

  l2_port_arbiter #(
    .NREQ(3),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .mem_ack(mem_ack),
    .gnt(gnt),
    .sel(sel),
    .mem_req(mem_req),
    .done(done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct packed {
    logic        dn;
    logic [2:0]  v;
    logic [1:0]  s;
    logic        t;
    logic [31:0] at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  function automatic logic [1:0] idx(input logic [2:0] oh);
    case (oh)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic take(input ev_t a);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got %h want none", a);
    end else begin
      e = exp_q.pop_front();
      chk(a.dn ? "done_event" : "grant_event", 64'(a), 64'(e));
    end
  endtask

  // monitor
  logic [2:0] pgnt = 3'b000;

  always @(negedge clk) begin
    ev_t a;
    logic ok;
    if (cyc > 0) begin
      if (!rst_q) begin
        chk("reset_values",
            {53'd0, gnt, sel, mem_req, done, busy, timeout_err},
            {53'd0, 3'b000, 2'b11, 1'b0, 3'b000, 1'b0, 1'b0});
      end else begin
        ok = $onehot0(gnt) && $onehot0(done)
          && ((sel == 2'b11) == (gnt == 3'b000))
          && (gnt == 3'b000 || sel == idx(gnt))
          && (mem_req == |gnt)
          && !(|done && |gnt)
          && (busy == (|gnt || |done))
          && (!timeout_err || |done);
        chk("invariants",
            {52'd0, ok, gnt, sel, mem_req, done, busy,
             timeout_err},
            {52'd0, 1'b1, gnt, sel, mem_req, done, busy,
             timeout_err});
        if (pgnt != 3'b000 && gnt != 3'b000)
          chk("grant_hold", 64'(gnt), 64'(pgnt));
        if (gnt != 3'b000 && pgnt == 3'b000) begin
          a = '{dn: 1'b0, v: gnt, s: sel, t: timeout_err,
                at: cyc};
          take(a);
        end
        if (done != 3'b000) begin
          a = '{dn: 1'b1, v: done, s: sel, t: timeout_err,
                at: cyc};
          take(a);
        end
      end
    end
    pgnt = gnt;
  end

  // stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dn, input logic [2:0] v,
                      input logic [1:0] s, input logic t,
                      input int at);
    ev_t e;
    e = '{dn: dn, v: v, s: s, t: t, at: at};
    exp_q.push_back(e);
  endtask

  // One transaction from an IDLE arbiter. ackk = BUSY cycle
  // (1-based) carrying mem_ack; 0 means no ack (watchdog).
  task automatic xact(input logic [2:0] rq,
                      input logic [2:0] mid,
                      input logic [2:0] win,
                      input int ackk,
                      input logic [2:0] relrq);
    int c;
    int d;
    c = cyc;
    d = (ackk == 0) ? c + 1 + TMO : c + ackk + 1;
    req = rq;
    push(1'b0, win, idx(win), 1'b0, c + 1);
    push(1'b1, win, 2'b11, ackk == 0, d);
    tick();
    req = mid;
    while (cyc < d) begin
      mem_ack = (ackk != 0 && cyc == c + ackk);
      tick();
    end
    mem_ack = 1'b0;
    req = relrq;
    tick();
  endtask

  initial begin
    int c;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // single D-refill, ack in third BUSY cycle; leaves ptr=2
    xact(3'b010, 3'b010, 3'b010, 3, 3'b000);
    // ptr=2 makes requester 2 beat requester 0
    xact(3'b101, 3'b101, 3'b100, 1, 3'b000);
    // all requesting: rotation 0,1,2,0
    xact(3'b111, 3'b111, 3'b001, 2, 3'b111);
    xact(3'b111, 3'b111, 3'b010, 2, 3'b111);
    xact(3'b111, 3'b111, 3'b100, 2, 3'b111);
    xact(3'b111, 3'b111, 3'b001, 2, 3'b000);
    // watchdog release, then ack exactly on the last cycle
    xact(3'b100, 3'b100, 3'b100, 0, 3'b000);
    xact(3'b100, 3'b100, 3'b100, TMO, 3'b000);
    // winner drops req mid-transaction while 1 rises
    xact(3'b001, 3'b010, 3'b001, 2, 3'b010);
    xact(3'b010, 3'b010, 3'b010, 1, 3'b000);

    // stray ack while idle must do nothing
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();

    // reset in the middle of a transaction: no done pulse
    c = cyc;
    req = 3'b010;
    push(1'b0, 3'b010, 2'b01, 1'b0, c + 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 3'b000;
    tick();
    // ptr back to 0 after reset
    xact(3'b101, 3'b101, 3'b001, 1, 3'b000);
    xact(3'b100, 3'b100, 3'b100, 1, 3'b000);

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
